// File: rtl/ofm_collector.sv
// OFM collector: captures 16-byte PE output vectors into a small FIFO and
// drains each as four big-endian 32-bit words to the OFM BRAM write port.
module ofm_collector #(
  parameter int unsigned       NUM_PIXELS = 3136,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic [15:0]       valid,
  input  logic [7:0]        OFM_0,
  input  logic [7:0]        OFM_1,
  input  logic [7:0]        OFM_2,
  input  logic [7:0]        OFM_3,
  input  logic [7:0]        OFM_4,
  input  logic [7:0]        OFM_5,
  input  logic [7:0]        OFM_6,
  input  logic [7:0]        OFM_7,
  input  logic [7:0]        OFM_8,
  input  logic [7:0]        OFM_9,
  input  logic [7:0]        OFM_10,
  input  logic [7:0]        OFM_11,
  input  logic [7:0]        OFM_12,
  input  logic [7:0]        OFM_13,
  input  logic [7:0]        OFM_14,
  input  logic [7:0]        OFM_15,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [11:0]       vec_count,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              lane_err
);

  localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [11:0]    NPIX    = 12'(NUM_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [127:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_word;
  logic [11:0]      r_cap_cnt;

  logic [127:0]     w_vec, w_head;
  logic             w_all, w_run, w_full, w_more;
  logic             w_cap, w_drop, w_bad, w_accept, w_pop, w_last;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W:0]   w_remain, w_count_nxt;
  logic [1:0]       w_word_nxt;
  logic [31:0]      w_data_nxt;

  assign w_vec = {OFM_0, OFM_1, OFM_2, OFM_3, OFM_4, OFM_5, OFM_6, OFM_7,
                  OFM_8, OFM_9, OFM_10, OFM_11, OFM_12, OFM_13, OFM_14, OFM_15};

  always_comb begin
    w_all       = (valid == '1);
    w_run       = (r_state == S_RUN);
    w_full      = (r_count == DEPTH_C);
    w_more      = (r_cap_cnt < NPIX);
    w_cap       = w_run & w_all & ~w_full & w_more;
    w_drop      = w_run & w_all & w_full & w_more;
    w_bad       = w_run & ~w_all & (valid != '0);
    w_accept    = wr_en & wr_ready;
    w_pop       = w_accept & (r_word == 2'd3);
    w_last      = w_pop & (vec_count == NPIX - 12'd1);
    w_rptr_nxt  = r_rptr + PTR_W'(w_pop);
    w_word_nxt  = r_word + 2'(w_accept);
    w_remain    = r_count - (PTR_W+1)'(w_pop);
    w_count_nxt = w_remain + (PTR_W+1)'(w_cap);
    // Outputs are registered, so a vector landing in an empty FIFO must be
    // presented straight from the inputs rather than from the memory.
    w_head      = (w_remain == '0) ? w_vec : r_mem[w_rptr_nxt];
    case (w_word_nxt)
      2'd0:    w_data_nxt = w_head[127:96];
      2'd1:    w_data_nxt = w_head[95:64];
      2'd2:    w_data_nxt = w_head[63:32];
      default: w_data_nxt = w_head[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_mem[r_wptr] <= w_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_word    <= '0;
      r_cap_cnt <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= '0;
      vec_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      lane_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          wr_en <= 1'b0;
          if (cal_start) begin
            r_state   <= S_RUN;
            busy      <= 1'b1;
            vec_count <= '0;
            r_cap_cnt <= '0;
            wr_addr   <= BASE_ADDR;
            overflow  <= 1'b0;
            lane_err  <= 1'b0;
          end
        end
        S_RUN: begin
          r_count <= w_count_nxt;
          r_rptr  <= w_rptr_nxt;
          r_word  <= w_word_nxt;
          wr_en   <= (w_count_nxt != '0);
          wr_data <= w_data_nxt;
          if (w_cap) begin
            r_wptr    <= r_wptr + PTR_W'(1);
            r_cap_cnt <= r_cap_cnt + 12'd1;
          end
          if (w_accept) wr_addr <= wr_addr + ADDR_W'(1);
          if (w_pop && vec_count != NPIX) vec_count <= vec_count + 12'd1;
          if (w_drop) overflow <= 1'b1;
          if (w_bad) lane_err <= 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          wr_en <= 1'b0;
          if (!cal_start) begin
            r_state <= S_IDLE;
            done    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_collector.sv
// Bench for ofm_collector: random and directed stimulus checked every cycle
// against a queue-based scoreboard of expected BRAM writes and status flags.
module tb_ofm_collector;

  localparam int unsigned   NP    = 8;
  localparam int unsigned   DEPTH = 4;
  localparam int unsigned   AW    = 20;
  localparam logic [AW-1:0] BASE  = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cal_start = 1'b0;
  logic          wr_ready = 1'b0;
  logic [15:0]   valid = '0;
  logic [7:0]    ofm [16];
  logic          wr_en, busy, done, overflow, lane_err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [11:0]   vec_count;

  ofm_collector #(
    .NUM_PIXELS(NP), .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .cal_start(cal_start), .valid(valid),
    .OFM_0(ofm[0]), .OFM_1(ofm[1]), .OFM_2(ofm[2]), .OFM_3(ofm[3]),
    .OFM_4(ofm[4]), .OFM_5(ofm[5]), .OFM_6(ofm[6]), .OFM_7(ofm[7]),
    .OFM_8(ofm[8]), .OFM_9(ofm[9]), .OFM_10(ofm[10]), .OFM_11(ofm[11]),
    .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .vec_count(vec_count), .busy(busy), .done(done),
    .overflow(overflow), .lane_err(lane_err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t       m_state;
  logic [AW-1:0] q_addr [$];
  logic [31:0]   q_data [$];
  int unsigned   m_occ, m_cap, m_vec, m_wcnt;
  logic          m_ovf, m_lerr;
  int unsigned   dut_words = 0;

  task automatic model_reset();
    m_state = M_IDLE;
    q_addr.delete();
    q_data.delete();
    m_occ = 0; m_cap = 0; m_vec = 0; m_wcnt = 0;
    m_ovf = 1'b0; m_lerr = 1'b0;
  endtask

  // Compare at the falling edge, then predict what the next rising edge does.
  task automatic tick();
    logic acc;
    @(negedge clk);
    check("wr_en", wr_en, q_data.size() != 0);
    if (wr_en && q_data.size() != 0) begin
      check("wr_addr", wr_addr, q_addr[0]);
      check("wr_data", wr_data, q_data[0]);
    end
    check("vec_count", vec_count, m_vec);
    check("busy", busy, m_state == M_RUN);
    check("done", done, m_state == M_DONE);
    check("overflow", overflow, m_ovf);
    check("lane_err", lane_err, m_lerr);
    if (wr_en && wr_ready) dut_words++;
    if (reset) begin
      case (m_state)
        M_IDLE: if (cal_start) begin
          m_state = M_RUN; m_vec = 0; m_cap = 0; m_ovf = 1'b0; m_lerr = 1'b0;
        end
        M_RUN: begin
          acc = wr_ready && (q_data.size() != 0);
          if (valid == 16'hFFFF) begin
            if (m_cap < NP) begin
              if (m_occ < DEPTH) begin
                for (int k = 0; k < 4; k++) begin
                  q_addr.push_back(BASE + AW'(4 * m_cap + k));
                  q_data.push_back({ofm[4*k], ofm[4*k+1], ofm[4*k+2], ofm[4*k+3]});
                end
                m_occ++;
                m_cap++;
              end else m_ovf = 1'b1;
            end
          end else if (valid != 16'h0000) m_lerr = 1'b1;
          if (acc) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            m_wcnt++;
            if (m_wcnt == 4) begin
              m_wcnt = 0;
              m_occ--;
              if (m_vec < NP) m_vec++;
              if (m_vec == NP) m_state = M_DONE;
            end
          end
        end
        default: if (!cal_start) m_state = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 16; i++) ofm[i] = 8'($urandom);
  endtask

  task automatic drain();
    wr_ready = 1'b1;
    valid = '0;
    for (int n = 0; n < 100 && q_data.size() != 0; n++) tick();
    tick();
  endtask

  int unsigned w0;

  initial begin
    for (int i = 0; i < 16; i++) ofm[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_flags", {busy, done, overflow, lane_err}, 0);

    // 1: single vector with OFM_i = i
    reset = 1'b1;
    cal_start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) ofm[i] = 8'(i);
    valid = 16'hFFFF;
    wr_ready = 1'b1;
    tick();
    valid = '0;
    check("t1_first_word", wr_data, 32'h00010203);
    w0 = dut_words;
    drain();
    check("t1_words", dut_words - w0, 4);
    check("t1_vec_count", vec_count, 1);

    // 2: back-pressure during word 1
    rand_vec();
    valid = 16'hFFFF;
    tick();
    valid = '0;
    tick();
    wr_ready = 1'b0;
    repeat (5) tick();
    check("t2_hold_addr", wr_addr, BASE + 20'd5);
    w0 = dut_words;
    drain();
    check("t2_words", dut_words - w0, 3);

    // 3: FIFO overflow with the sink stalled
    wr_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      rand_vec();
      valid = 16'hFFFF;
      tick();
    end
    valid = '0;
    tick();
    check("t3_overflow", overflow, 1);
    w0 = dut_words;
    drain();
    check("t3_words", dut_words - w0, 16);

    // 4: partial lanes
    valid = 16'h00FF;
    tick();
    valid = '0;
    tick();
    check("t4_lane_err", lane_err, 1);
    check("t4_vec_count", vec_count, 6);

    // 5: full (small) feature map at PE pacing with random back-pressure
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    w0 = dut_words;
    for (int v = 0; v < NP; v++) begin
      rand_vec();
      valid = 16'hFFFF;
      wr_ready = ($urandom_range(3) != 0);
      tick();
      for (int c = 0; c < 35; c++) begin
        valid = ($urandom_range(15) == 0) ? 16'($urandom) : 16'h0000;
        if (valid == 16'hFFFF) valid = 16'h0001;
        wr_ready = ($urandom_range(3) != 0);
        tick();
      end
    end
    drain();
    check("t5_words", dut_words - w0, 32);
    check("t5_done", done, 1);
    check("t5_no_overflow", overflow, 0);
    cal_start = 1'b0;
    tick();
    tick();
    check("t5_idle", {busy, done}, 0);
    cal_start = 1'b1;
    tick();
    check("t5_restart_cnt", vec_count, 0);
    check("t5_restart_addr", wr_addr, BASE);

    // random stress until the map completes
    for (int c = 0; c < 3000 && m_state != M_DONE; c++) begin
      rand_vec();
      case ($urandom_range(7))
        0, 1, 2: valid = 16'hFFFF;
        3:       valid = 16'($urandom);
        default: valid = 16'h0000;
      endcase
      wr_ready = $urandom_range(1) != 0;
      tick();
    end
    valid = '0;
    tick();
    check("stress_done", done, 1);
    cal_start = 1'b0;
    tick();

    // 6: reset while vectors are buffered
    cal_start = 1'b1;
    tick();
    wr_ready = 1'b0;
    for (int v = 0; v < 2; v++) begin
      rand_vec();
      valid = 16'hFFFF;
      tick();
    end
    valid = '0;
    tick();
    check("t6_wr_en_before", wr_en, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_wr_en_async", wr_en, 0);
    model_reset();
    tick();
    reset = 1'b1;
    cal_start = 1'b0;
    wr_ready = 1'b1;
    w0 = dut_words;
    repeat (5) tick();
    check("t6_no_residual", dut_words - w0, 0);
    check("t6_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
